y86_regfile_sb: RTL
===================

# y86_regfile_sb

Parametrised Y86 register file with two read ports, two write-back ports (E and M), and a per-register pending scoreboard. It sits between decode and write-back. Decode reads operands and reserves destinations. Write-back commits results and releases reservations. A compile-time bypass forwards same-cycle write data to the read ports.

## Interface
Parameters:
- WIDTH, 32, register data width in bits
- NREGS, 8, number of architectural registers; must be ≤ 2^IDW − 1
- IDW, 4, register-ID width
- NOREG, 4'hF, ID meaning "no register"; must be ≥ NREGS
- PEND_W, 2, width of each per-register pending counter
- SP_INIT, 32'h0, reset value of register 4 (%esp)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- srcA  in  IDW  read-port A register ID
- srcB  in  IDW  read-port B register ID
- dstE  in  IDW  write port E destination (NOREG = no write)
- dstM  in  IDW  write port M destination (NOREG = no write)
- valE  in  WIDTH  write port E data
- valM  in  WIDTH  write port M data
- rsvE  in  IDW  reserve destination for E result (NOREG = none)
- rsvM  in  IDW  reserve destination for M result (NOREG = none)
- valA  out  WIDTH  read data A
- valB  out  WIDTH  read data B
- busyA  out  1  srcA has a pending write
- busyB  out  1  srcB has a pending write
- err  out  1  sticky error flag: counter overflow, counter underflow, or ID out of range

## Operation
- Register storage: NREGS × WIDTH.
  - On reset, all registers clear to 0, except register 4, which loads SP_INIT.
  - Reset also clears all pending counters and err.
- Write:
  - At posedge, if dstE ≠ NOREG then regs[dstE] ← valE.
  - If dstM ≠ NOREG then regs[dstM] ← valM.
  - If dstE = dstM ≠ NOREG, valM wins.
- Read (combinational):
  - valA = regs[srcA]; valB = regs[srcB].
  - srcX = NOREG or srcX ≥ NREGS gives 0. No latching of a stale value.
- Scoreboard: one PEND_W-bit counter per register.
  - Each valid rsvE/rsvM increments the target counter by 1.
  - Each valid dstE/dstM decrements the target counter by 1.
  - Net change per cycle = (#reserves) − (#releases), range −2..+2.
  - Equal reserve and release on the same register in the same cycle leaves the counter unchanged.
- Counter limits:
  - A result above 2^PEND_W − 1 saturates at max and sets err.
  - A result below 0 clamps at 0 and sets err.
- busyX = (srcX ≠ NOREG) and (pend[srcX] ≠ 0) and not forwarded (see Configuration).
- ID range: any non-NOREG ID ≥ NREGS on dst*, rsv* or src* sets err. The access is ignored: no write, no counter change, read 0.
- err stays set until rst.

## Timing
- Write latency: one cycle. Data written at edge N is visible on valA/valB after edge N.
- Read path: combinational from src* (and from dst*/val* when bypass is on). No read latency.
- Reserve at edge N asserts busy after edge N.
- Release at edge N deasserts busy after edge N when the counter reaches 0.
- Outputs during reset: valA/valB = 0 (reg 4 reads SP_INIT); busyA/busyB = 0; err = 0.
- Reset mid-operation clears every counter immediately, independent of clk. In-flight releases arriving after reset are underflows and set err; the pipeline flushes with rst.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If srcX matches a valid dstM, valX = valM.
  - Else if srcX matches a valid dstE, valX = valE.
  - Either match forces busyX = 0 when pend[srcX] = 1, i.e. the final write is arriving now.
- Undefined: reads return only committed register contents; busy reflects the counter alone.

## Test plan
- Reset with SP_INIT = 32'h100 → reg4 reads 32'h100, all others 0, busyA/B = 0, err = 0.
- dstE = dstM = 2, valE = 32'h11, valM = 32'h22 → after edge, reg2 = 32'h22.
- rsvE = 3 for three cycles with PEND_W = 2, then three releases → busyA (srcA = 3) high throughout, low after the third release, err = 0. A fourth reserve at count 3 → err = 1, counter stays 3.
- Simultaneous rsvE = 5 and dstE = 5 with count 1 → count stays 1, busy stays high.
- Bypass on: srcA = 1, dstE = 1, valE = 32'hDEAD, pend[1] = 1 → valA = 32'hDEAD and busyA = 0 in the same cycle. Bypass off: old value and busyA = 1.
- Release dstM = 6 with count 0, and srcB = 9 with NREGS = 8 → err = 1, valB = 0, counter stays 0.

Source files
------------

// File: rtl/y86_regfile_sb.sv
// Y86 register file: two read ports, E/M write-back ports, per-register pending scoreboard, sticky err.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module y86_regfile_sb #(
  parameter int              WIDTH   = 32,
  parameter int              NREGS   = 8,
  parameter int              IDW     = 4,
  parameter logic [IDW-1:0]  NOREG   = 4'hF,
  parameter int              PEND_W  = 2,
  parameter logic [WIDTH-1:0] SP_INIT = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDW-1:0]   srcA,
  input  logic [IDW-1:0]   srcB,
  input  logic [IDW-1:0]   dstE,
  input  logic [IDW-1:0]   dstM,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic [IDW-1:0]   rsvE,
  input  logic [IDW-1:0]   rsvM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             busyA,
  output logic             busyB,
  output logic             err
);
  localparam int                AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int                CW      = PEND_W + 2;
  localparam logic [IDW:0]      NREGS_W = (IDW+1)'(NREGS);
  localparam logic [PEND_W-1:0] PMAX    = '1;

  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [WIDTH-1:0]  regs_d [NREGS];
  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];
  logic              err_q, err_d;

  function automatic logic id_ok(input logic [IDW-1:0] id);
    return (id != NOREG) && ({1'b0, id} < NREGS_W);
  endfunction

  function automatic logic id_bad(input logic [IDW-1:0] id);
    return (id != NOREG) && !({1'b0, id} < NREGS_W);
  endfunction

  logic dstE_v, dstM_v, rsvE_v, rsvM_v;
  assign dstE_v = id_ok(dstE);
  assign dstM_v = id_ok(dstM);
  assign rsvE_v = id_ok(rsvE);
  assign rsvM_v = id_ok(rsvM);

  // Write-back and scoreboard next state; the counter sum is widened so both limits are detectable.
  always_comb begin
    logic [1:0]    inc, dec;
    logic [CW-1:0] sum;
    err_d = err_q | id_bad(dstE) | id_bad(dstM) | id_bad(rsvE) | id_bad(rsvM)
                  | id_bad(srcA) | id_bad(srcB);
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (dstE_v && dstE == IDW'(i)) regs_d[i] = valE;
      if (dstM_v && dstM == IDW'(i)) regs_d[i] = valM;

      inc = {1'b0, rsvE_v && rsvE == IDW'(i)} + {1'b0, rsvM_v && rsvM == IDW'(i)};
      dec = {1'b0, dstE_v && dstE == IDW'(i)} + {1'b0, dstM_v && dstM == IDW'(i)};
      sum = {2'b00, pend_q[i]} + CW'(inc);
      if (sum < CW'(dec)) begin
        pend_d[i] = '0;
        err_d     = 1'b1;
      end else begin
        sum = sum - CW'(dec);
        if (sum > CW'(PMAX)) begin
          pend_d[i] = PMAX;
          err_d     = 1'b1;
        end else begin
          pend_d[i] = sum[PEND_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 4) ? SP_INIT : '0;
        pend_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  logic [IDW-1:0]   src     [2];
  logic [WIDTH-1:0] rd_val  [2];
  logic             rd_busy [2];
  assign src[0] = srcA;
  assign src[1] = srcB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p]  = '0;
      rd_busy[p] = 1'b0;
      if (id_ok(src[p])) begin
        rd_val[p]  = regs_q[src[p][AW-1:0]];
        rd_busy[p] = (pend_q[src[p][AW-1:0]] != '0);
`ifdef REGFILE_BYPASS_EN
        // The last outstanding write landing this cycle clears busy along with forwarding its data.
        if (dstM_v && dstM == src[p]) begin
          rd_val[p] = valM;
        end else if (dstE_v && dstE == src[p]) begin
          rd_val[p] = valE;
        end
        if (((dstM_v && dstM == src[p]) || (dstE_v && dstE == src[p])) &&
            pend_q[src[p][AW-1:0]] == PEND_W'(1)) begin
          rd_busy[p] = 1'b0;
        end
`endif
      end
    end
  end

  assign valA  = rd_val[0];
  assign valB  = rd_val[1];
  assign busyA = rd_busy[0];
  assign busyB = rd_busy[1];
  assign err   = err_q;

endmodule
